// File: rtl/layer1_pipe_reg.sv
// layer1_pipe_reg: valid/ready pipeline stage between the layer-1 LUT neurons
// and the layer-2 inputs. A two-entry skid buffer gives full throughput with a
// registered in_ready. It also keeps a wrapping delivered-vector count and a
// saturating stall-cycle count.
// Optional feature: define LAYER1_PIPE_PARITY_EN to add out_parity, the XOR of
// out_data. The parity is stored per entry so it stays aligned with out_data.
module layer1_pipe_reg #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] stall_cnt
`ifdef LAYER1_PIPE_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
`ifdef LAYER1_PIPE_PARITY_EN
  logic             main_par_q, main_par_d;
  logic             skid_par_q, skid_par_d;
`endif

  logic in_fire;
  logic out_fire;

  // Handshakes are qualified only by registered flags, so out_ready never
  // reaches in_ready combinationally.
  assign in_fire  = in_valid && in_ready_q;
  assign out_fire = out_valid_q && out_ready;

  // Next-state, data-steering and counter logic.
  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    state_d     = state_q;
    main_d      = main_q;
    skid_d      = skid_q;
    frame_cnt_d = frame_cnt_q;
    stall_cnt_d = stall_cnt_q;
`ifdef LAYER1_PIPE_PARITY_EN
    main_par_d  = main_par_q;
    skid_par_d  = skid_par_q;
`endif

    unique case (state_q)
      S_EMPTY: begin
        if (in_fire) begin
          main_d  = in_data;
          state_d = S_ONE;
`ifdef LAYER1_PIPE_PARITY_EN
          main_par_d = ^in_data;
`endif
        end
      end
      S_ONE: begin
        if (in_fire && !out_fire) begin
          skid_d  = in_data;
          state_d = S_TWO;
`ifdef LAYER1_PIPE_PARITY_EN
          skid_par_d = ^in_data;
`endif
        end else if (in_fire && out_fire) begin
          main_d  = in_data;
`ifdef LAYER1_PIPE_PARITY_EN
          main_par_d = ^in_data;
`endif
        end else if (out_fire) begin
          state_d = S_EMPTY;
        end
      end
      S_TWO: begin
        if (out_fire) begin
          main_d  = skid_q;
          state_d = S_ONE;
`ifdef LAYER1_PIPE_PARITY_EN
          main_par_d = skid_par_q;
`endif
        end
      end
      default: state_d = S_EMPTY;
    endcase

    // Flush empties the buffer and discards any vector offered this cycle.
    if (flush) begin
      state_d = S_EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
`ifdef LAYER1_PIPE_PARITY_EN
      main_par_d = main_par_q;
      skid_par_d = skid_par_q;
`endif
    end

    if (out_fire) begin
      frame_cnt_d = frame_cnt_q + CNT_W'(1);
    end
    if (out_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // Handshake flags are decoded from the next state and registered.
  assign out_valid_d = (state_d != S_EMPTY);
  assign in_ready_d  = (state_d != S_TWO);

  // State, data and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, independent of statement order.
    if (rst) begin
      state_q     <= S_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      main_q      <= '0;
      // NOTE: the skid entry is cleared too, so it never holds X that a later
      // skid-to-main move could expose on out_data.
      skid_q      <= '0;
      frame_cnt_q <= '0;
      stall_cnt_q <= '0;
`ifdef LAYER1_PIPE_PARITY_EN
      main_par_q  <= 1'b0;
      skid_par_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      frame_cnt_q <= frame_cnt_d;
      stall_cnt_q <= stall_cnt_d;
`ifdef LAYER1_PIPE_PARITY_EN
      main_par_q  <= main_par_d;
      skid_par_q  <= skid_par_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign frame_cnt = frame_cnt_q;
  assign stall_cnt = stall_cnt_q;
`ifdef LAYER1_PIPE_PARITY_EN
  assign out_parity = main_par_q;
`endif

endmodule

// File: tb/tb_layer1_pipe_reg.sv
// tb_layer1_pipe_reg: directed-vector bench for layer1_pipe_reg. A 64-bit,
// 16-bit-counter instance covers the handshake behaviour. A small 8-bit,
// 4-bit-counter instance covers counter wrap and saturation.
// Build with LAYER1_PIPE_PARITY_EN defined to also check out_parity.
module tb_layer1_pipe_reg;

  logic        clk;
  logic        rst;

  logic        flush, in_valid, in_ready, out_valid, out_ready;
  logic [63:0] in_data, out_data;
  logic [15:0] frame_cnt, stall_cnt;

  logic        s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [7:0]  s_in_data, s_out_data;
  logic [3:0]  s_frame_cnt, s_stall_cnt;

`ifdef LAYER1_PIPE_PARITY_EN
  logic        out_parity, s_out_parity;
`endif

  int total = 0;
  int bad   = 0;

  layer1_pipe_reg #(.WIDTH(64), .CNT_W(16)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .frame_cnt (frame_cnt),
    .stall_cnt (stall_cnt)
`ifdef LAYER1_PIPE_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  layer1_pipe_reg #(.WIDTH(8), .CNT_W(4)) u_dut_small (
    .clk       (clk),
    .rst       (rst),
    .flush     (s_flush),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .in_data   (s_in_data),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .out_data  (s_out_data),
    .frame_cnt (s_frame_cnt),
    .stall_cnt (s_stall_cnt)
`ifdef LAYER1_PIPE_PARITY_EN
    ,
    .out_parity(s_out_parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 64'hDEAD_BEEF; out_ready = 1'b0;
    s_flush = 1'b0; s_in_valid = 1'b0; s_in_data = 8'h0; s_out_ready = 1'b0;

    // Reset held two cycles with in_valid asserted.
    for (int c = 0; c < 2; c++) begin
      tick();
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_data", out_data, 64'd0);
      check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
      check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    end
    rst = 1'b0; in_valid = 1'b0;
    tick();
    check("post_rst_out_valid", 64'(out_valid), 64'd0);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    check("post_rst_frame_cnt", 64'(frame_cnt), 64'd0);
`ifdef LAYER1_PIPE_PARITY_EN
    check("rst_parity", 64'(out_parity), 64'd0);
`endif

    // Streaming 0x1..0x10 with out_ready=1: one-cycle latency, no gaps.
    out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      in_valid = 1'b1; in_data = 64'(i);
      tick();
      check("stream_valid", 64'(out_valid), 64'd1);
      check("stream_data", out_data, 64'(i));
      check("stream_in_ready", 64'(in_ready), 64'd1);
`ifdef LAYER1_PIPE_PARITY_EN
      check("stream_parity", 64'(out_parity), 64'(^(i[7:0])));
`endif
    end
    in_valid = 1'b0;
    tick();
    check("stream_drain_valid", 64'(out_valid), 64'd0);
    check("stream_frame_cnt", 64'(frame_cnt), 64'd16);

    // Backpressure: A then B with out_ready=0.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 64'hAAAA_0000_0000_000A;
    tick();
    check("bp_a_data", out_data, 64'hAAAA_0000_0000_000A);
    check("bp_a_in_ready", 64'(in_ready), 64'd1);
    in_data = 64'hBBBB_0000_0000_000B;
    tick();
    check("bp_two_in_ready", 64'(in_ready), 64'd0);
    check("bp_stall_1", 64'(stall_cnt), 64'd1);
    // C is offered while full and must be refused.
    in_data = 64'hCCCC_0000_0000_000C;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("bp_hold_data", out_data, 64'hAAAA_0000_0000_000A);
      check("bp_hold_valid", 64'(out_valid), 64'd1);
      check("bp_hold_in_ready", 64'(in_ready), 64'd0);
    end
    check("bp_stall_5", 64'(stall_cnt), 64'd5);
    check("bp_frame_hold", 64'(frame_cnt), 64'd16);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("bp_b_data", out_data, 64'hBBBB_0000_0000_000B);
    check("bp_b_valid", 64'(out_valid), 64'd1);
    check("bp_b_frame", 64'(frame_cnt), 64'd17);
    tick();
    check("bp_empty_valid", 64'(out_valid), 64'd0);
    check("bp_frame_end", 64'(frame_cnt), 64'd18);
    check("bp_stall_end", 64'(stall_cnt), 64'd5);

    // Simultaneous input and output transfer in state ONE.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h0D;
    tick();
    check("sim_d_data", out_data, 64'h0D);
    out_ready = 1'b1; in_data = 64'h0E;
    tick();
    check("sim_e_data", out_data, 64'h0E);
    check("sim_e_valid", 64'(out_valid), 64'd1);
    check("sim_e_in_ready", 64'(in_ready), 64'd1);
    check("sim_frame", 64'(frame_cnt), 64'd19);
    in_valid = 1'b0;
    tick();
    check("sim_frame_end", 64'(frame_cnt), 64'd20);

    // Flush while in TWO with in_valid=1.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h0F;
    tick();
    in_data = 64'h10F;
    tick();
    check("fl_two_in_ready", 64'(in_ready), 64'd0);
    check("fl_stall_6", 64'(stall_cnt), 64'd6);
    flush = 1'b1; in_data = 64'h111;
    tick();
    check("fl_out_valid", 64'(out_valid), 64'd0);
    check("fl_in_ready", 64'(in_ready), 64'd1);
    check("fl_frame", 64'(frame_cnt), 64'd20);
    check("fl_stall_7", 64'(stall_cnt), 64'd7);
    flush = 1'b0; in_valid = 1'b0;
    tick();
    check("fl_dropped_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1; in_valid = 1'b1; in_data = 64'h1234;
    tick();
    check("fl_next_data", out_data, 64'h1234);
    in_valid = 1'b0;
    tick();
    check("fl_next_frame", 64'(frame_cnt), 64'd21);

    // Small instance: 17 transfers wrap a 4-bit frame counter to 1.
    s_out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      s_in_valid = 1'b1; s_in_data = 8'(i + 1);
      tick();
    end
    s_in_valid = 1'b0;
    tick();
    check("small_frame_wrap", 64'(s_frame_cnt), 64'd1);

    // Small instance: 20 stalled cycles saturate the stall counter at 15.
    s_out_ready = 1'b0; s_in_valid = 1'b1; s_in_data = 8'h07;
    tick();
    s_in_valid = 1'b0;
    check("small_data_7", 64'(s_out_data), 64'h07);
`ifdef LAYER1_PIPE_PARITY_EN
    check("small_parity_7", 64'(s_out_parity), 64'd1);
`endif
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 14) check("small_stall_14", 64'(s_stall_cnt), 64'd14);
    end
    check("small_stall_sat", 64'(s_stall_cnt), 64'd15);
    check("small_hold_data", 64'(s_out_data), 64'h07);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
